// File: rtl/kws_pkg.sv
// Shared definitions for the keyword-spotting class decision stage:
// FSM state encoding, index-width helper and the default silence class.
package kws_pkg;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE   = 2'd0;
  localparam fsm_state_t ST_SCAN   = 2'd1;
  localparam fsm_state_t ST_DECIDE = 2'd2;

  localparam int SILENCE_CLASS_DEFAULT = 0;

  // Bits needed to index n items; never less than one bit.
  function automatic int class_idx_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/kws_hit_filter.sv
// Consecutive-hit filter: counts back-to-back qualifying frames of the same
// non-silence class and pulses detect once when the streak reaches HIT_COUNT.
module kws_hit_filter
  import kws_pkg::*;
#(
  parameter int ACTIV_BITS    = 8,
  parameter int CLASS_BITS    = 4,
  parameter int HIT_COUNT     = 3,
  parameter int SILENCE_CLASS = SILENCE_CLASS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [CLASS_BITS-1:0] idx,
  input  logic [ACTIV_BITS-1:0] score,
  input  logic [ACTIV_BITS-1:0] threshold,
  output logic                  detect
);

  localparam int CNT_BITS = class_idx_bits(HIT_COUNT + 1);
  localparam logic [CNT_BITS-1:0]   HIT_MAX     = CNT_BITS'(HIT_COUNT);
  localparam logic [CLASS_BITS-1:0] SILENCE_IDX = CLASS_BITS'(SILENCE_CLASS);

  logic [CNT_BITS-1:0]   hit_cnt_reg;
  logic [CNT_BITS-1:0]   hit_cnt_next;
  logic [CLASS_BITS-1:0] last_idx_reg;
  logic                  detect_reg;
  logic                  detect_next;
  logic                  qualifies;
  logic                  same_class;

  assign qualifies  = (score >= threshold) && (idx != SILENCE_IDX);
  assign same_class = (idx == last_idx_reg);

  always_comb begin
    hit_cnt_next = hit_cnt_reg;
    detect_next  = 1'b0;
    if (valid) begin
      if (!qualifies) begin
        hit_cnt_next = '0;
      end else if (same_class) begin
        hit_cnt_next = (hit_cnt_reg == HIT_MAX) ? HIT_MAX : hit_cnt_reg + CNT_BITS'(1);
      end else begin
        hit_cnt_next = CNT_BITS'(1);
      end
      // A saturated streak of the same class must not fire again.
      detect_next = qualifies && (hit_cnt_next == HIT_MAX)
                    && !(same_class && hit_cnt_reg == HIT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_reg  <= '0;
      last_idx_reg <= SILENCE_IDX;
      detect_reg   <= 1'b0;
    end else begin
      hit_cnt_reg <= hit_cnt_next;
      detect_reg  <= detect_next;
      if (valid) begin
        last_idx_reg <= idx;
      end
    end
  end

  assign detect = detect_reg;

endmodule

// File: rtl/kws_class_decision.sv
// Serial arg-max over one softmax frame per data_valid, followed by a
// consecutive-hit filter that raises detect on a completed keyword streak.
module kws_class_decision
  import kws_pkg::*;
#(
  parameter int INPUT_SIZE    = 10,
  parameter int ACTIV_BITS    = 8,
  parameter int CLASS_BITS    = 4,
  parameter int HIT_COUNT     = 3,
  parameter int SILENCE_CLASS = SILENCE_CLASS_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [INPUT_SIZE*ACTIV_BITS-1:0] data_in,
  input  logic                             data_valid,
  input  logic [ACTIV_BITS-1:0]            threshold,
  output logic                             busy,
  output logic                             overrun,
  output logic [CLASS_BITS-1:0]            class_out,
  output logic [ACTIV_BITS-1:0]            class_score,
  output logic                             class_valid,
  output logic                             detect
);

  localparam logic [CLASS_BITS-1:0] LAST_IDX = CLASS_BITS'(INPUT_SIZE - 1);

  logic [ACTIV_BITS-1:0] elem_in   [INPUT_SIZE];
  logic [ACTIV_BITS-1:0] frame_reg [INPUT_SIZE];
  logic [ACTIV_BITS-1:0] thr_reg;
  fsm_state_t            state_reg;
  logic [CLASS_BITS-1:0] scan_idx_reg;
  logic [CLASS_BITS-1:0] best_idx_reg;
  logic [ACTIV_BITS-1:0] best_val_reg;
  logic [ACTIV_BITS-1:0] scan_val;
  logic                  busy_reg;
  logic                  overrun_reg;
  logic [CLASS_BITS-1:0] class_out_reg;
  logic [ACTIV_BITS-1:0] class_score_reg;
  logic                  class_valid_reg;
  logic                  accept;
  logic                  deciding;

  for (genvar gi = 0; gi < INPUT_SIZE; gi++) begin : g_unpack
    assign elem_in[gi] = data_in[gi*ACTIV_BITS +: ACTIV_BITS];
  end

  assign accept   = (state_reg == ST_IDLE) && data_valid;
  assign deciding = (state_reg == ST_DECIDE);
  assign scan_val = frame_reg[scan_idx_reg];

  // Frame buffer holds no reset value; it is only read after a fresh capture.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int i = 0; i < INPUT_SIZE; i++) begin
        frame_reg[i] <= elem_in[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      thr_reg         <= '0;
      scan_idx_reg    <= '0;
      best_idx_reg    <= '0;
      best_val_reg    <= '0;
      busy_reg        <= 1'b0;
      overrun_reg     <= 1'b0;
      class_out_reg   <= '0;
      class_score_reg <= '0;
      class_valid_reg <= 1'b0;
    end else begin
      overrun_reg     <= data_valid && busy_reg;
      class_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (data_valid) begin
            thr_reg      <= threshold;
            best_idx_reg <= '0;
            best_val_reg <= elem_in[0];
            scan_idx_reg <= CLASS_BITS'(1);
            busy_reg     <= 1'b1;
            state_reg    <= (INPUT_SIZE == 1) ? ST_DECIDE : ST_SCAN;
          end
        end
        ST_SCAN: begin
          // Strict compare so that ties keep the lower index.
          if (scan_val > best_val_reg) begin
            best_idx_reg <= scan_idx_reg;
            best_val_reg <= scan_val;
          end
          if (scan_idx_reg == LAST_IDX) begin
            state_reg <= ST_DECIDE;
          end else begin
            scan_idx_reg <= scan_idx_reg + CLASS_BITS'(1);
          end
        end
        ST_DECIDE: begin
          class_out_reg   <= best_idx_reg;
          class_score_reg <= best_val_reg;
          class_valid_reg <= 1'b1;
          busy_reg        <= 1'b0;
          state_reg       <= ST_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  kws_hit_filter #(
    .ACTIV_BITS   (ACTIV_BITS),
    .CLASS_BITS   (CLASS_BITS),
    .HIT_COUNT    (HIT_COUNT),
    .SILENCE_CLASS(SILENCE_CLASS)
  ) u_hit_filter (
    .clk      (clk),
    .rst      (rst),
    .valid    (deciding),
    .idx      (best_idx_reg),
    .score    (best_val_reg),
    .threshold(thr_reg),
    .detect   (detect)
  );

  assign busy        = busy_reg;
  assign overrun     = overrun_reg;
  assign class_out   = class_out_reg;
  assign class_score = class_score_reg;
  assign class_valid = class_valid_reg;

endmodule

// File: tb/tb_kws_class_decision.sv
// Randomised and directed bench for kws_class_decision with a behavioural
// arg-max / streak model; one line per frame, one summary line at the end.
module tb_kws_class_decision;

  localparam int N   = 10;
  localparam int AB  = 8;
  localparam int CB  = 4;
  localparam int HIT = 3;
  localparam int SIL = 0;
  localparam int L   = 2 * N + 3;

  typedef struct packed {
    int base;
    int c1;
    int v1;
    int c2;
    int v2;
    int thr;
  } stim_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*AB-1:0] data_in;
  logic            data_valid;
  logic [AB-1:0]   threshold;
  logic            busy;
  logic            overrun;
  logic [CB-1:0]   class_out;
  logic [AB-1:0]   class_score;
  logic            class_valid;
  logic            detect;

  kws_class_decision #(
    .INPUT_SIZE(N), .ACTIV_BITS(AB), .CLASS_BITS(CB),
    .HIT_COUNT(HIT), .SILENCE_CLASS(SIL)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .threshold(threshold), .busy(busy), .overrun(overrun),
    .class_out(class_out), .class_score(class_score),
    .class_valid(class_valid), .detect(detect)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state of the streak filter
  int m_cnt  = 0;
  int m_last = SIL;

  logic [AB-1:0] sc [N];
  logic [31:0]   busy_v, cv_v, ov_v, det_v;
  logic [CB-1:0] got_idx;
  logic [AB-1:0] got_score;

  function automatic logic [N*AB-1:0] pack_frame();
    logic [N*AB-1:0] f;
    for (int i = 0; i < N; i++) f[i*AB +: AB] = sc[i];
    return f;
  endfunction

  task automatic fill(input int base, input int c1, input int v1, input int c2, input int v2);
    for (int i = 0; i < N; i++) sc[i] = AB'(base);
    if (c2 >= 0) sc[c2] = AB'(v2);
    if (c1 >= 0) sc[c1] = AB'(v1);
  endtask

  // Reference: plain arg-max (first of the maxima) and the streak rules.
  task automatic ref_decide(input logic [N*AB-1:0] f, input int thr,
                            output int e_idx, output int e_val, output bit e_det);
    int prev;
    bit q;
    e_idx = 0;
    e_val = int'(f[0 +: AB]);
    for (int i = 1; i < N; i++) begin
      if (int'(f[i*AB +: AB]) > e_val) begin
        e_idx = i;
        e_val = int'(f[i*AB +: AB]);
      end
    end
    q    = (e_val >= thr) && (e_idx != SIL);
    prev = (e_idx == m_last) ? m_cnt : 0;
    if (!q) m_cnt = 0;
    else    m_cnt = (prev + 1 > HIT) ? HIT : prev + 1;
    e_det  = q && (m_cnt == HIT) && (prev < HIT);
    m_last = e_idx;
  endtask

  // Presents one frame and records per-cycle outputs after E0 .. E0+L-1.
  task automatic drive_frame(input logic [N*AB-1:0] f, input int thr,
                             input int ovr_at, input int rst_at);
    busy_v = '0; cv_v = '0; ov_v = '0; det_v = '0;
    got_idx = '0; got_score = '0;
    @(negedge clk);
    data_in    = f;
    threshold  = AB'(thr);
    data_valid = 1'b1;
    for (int k = 0; k < L; k++) begin
      if (k > 0 && k == ovr_at) begin
        data_in    = ~f;
        data_valid = 1'b1;
      end
      if (k > 0 && k == rst_at) rst = 1'b1;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      rst        = 1'b0;
      busy_v[k]  = busy;
      cv_v[k]    = class_valid;
      ov_v[k]    = overrun;
      det_v[k]   = detect;
      if (class_valid) begin
        got_idx   = class_out;
        got_score = class_score;
      end
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    data_valid = 1'b1;
    data_in    = {N{8'hC3}};
    threshold  = 8'd1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, overrun, class_valid, detect, class_out, class_score} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%0h exp=0",
               {busy, overrun, class_valid, detect, class_out, class_score});
    end
    @(negedge clk);
    rst        = 1'b0;
    data_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ignores_valid busy got=%0b exp=0", busy);
    end
    $display("reset: busy=%0b class_valid=%0b", busy, class_valid);
  endtask

  task automatic test_directed();
    stim_t tbl [13];
    logic [N*AB-1:0] f;
    int e_idx, e_val;
    bit e_det;
    tbl = '{
      '{5,   3, 200, 9, 10,  100},
      '{0,   2, 150, 7, 150, 200},
      '{20,  4, 180, -1, 0,  128}, '{20, 4, 180, -1, 0, 128},
      '{20,  4, 180, -1, 0,  128}, '{20, 4, 180, -1, 0, 128},
      '{20,  5, 180, -1, 0,  128}, '{20, 5, 180, -1, 0, 128},
      '{20,  5, 180, -1, 0,  128},
      '{0,   0, 255, -1, 0,  128}, '{0, 0, 255, -1, 0, 128},
      '{0,   0, 255, -1, 0,  128},
      '{10,  4, 100, -1, 0,  128}
    };
    for (int r = 0; r < 13; r++) begin
      fill(tbl[r].base, tbl[r].c1, tbl[r].v1, tbl[r].c2, tbl[r].v2);
      f = pack_frame();
      ref_decide(f, tbl[r].thr, e_idx, e_val, e_det);
      drive_frame(f, tbl[r].thr, 0, 0);
      total++;
      if (busy_v !== (32'd1 << N) - 32'd1) begin
        bad++;
        $display("FAIL dir_busy row=%0d got=%0h exp=%0h", r, busy_v, (32'd1 << N) - 32'd1);
      end
      total++;
      if (cv_v !== (32'd1 << N)) begin
        bad++;
        $display("FAIL dir_class_valid row=%0d got=%0h exp=%0h", r, cv_v, 32'd1 << N);
      end
      total++;
      if (got_idx !== CB'(e_idx) || got_score !== AB'(e_val)) begin
        bad++;
        $display("FAIL dir_class row=%0d got=%0d/%0d exp=%0d/%0d",
                 r, got_idx, got_score, e_idx, e_val);
      end
      total++;
      if (det_v !== (32'(e_det) << N)) begin
        bad++;
        $display("FAIL dir_detect row=%0d got=%0h exp=%0h", r, det_v, 32'(e_det) << N);
      end
      $display("frame %0d: class=%0d score=%0d detect=%0b", r, got_idx, got_score, det_v[N]);
    end
  endtask

  task automatic test_overrun();
    logic [N*AB-1:0] f;
    int e_idx, e_val;
    bit e_det;
    fill(10, 7, 90, -1, 0);
    f = pack_frame();
    ref_decide(f, 50, e_idx, e_val, e_det);
    drive_frame(f, 50, 3, 0);
    total++;
    if (ov_v !== (32'd1 << 3)) begin
      bad++;
      $display("FAIL overrun_pulse got=%0h exp=%0h", ov_v, 32'd1 << 3);
    end
    total++;
    if (cv_v !== (32'd1 << N)) begin
      bad++;
      $display("FAIL overrun_dropped_frame class_valid got=%0h exp=%0h", cv_v, 32'd1 << N);
    end
    total++;
    if (got_idx !== CB'(e_idx) || got_score !== AB'(e_val) || det_v !== (32'(e_det) << N)) begin
      bad++;
      $display("FAIL overrun_result got=%0d/%0d/%0h exp=%0d/%0d/%0h",
               got_idx, got_score, det_v, e_idx, e_val, 32'(e_det) << N);
    end
    $display("overrun: ov=%0h class=%0d score=%0d", ov_v, got_idx, got_score);
  endtask

  task automatic test_reset_mid_scan();
    logic [N*AB-1:0] f;
    int e_idx, e_val;
    bit e_det;
    fill(20, 4, 180, -1, 0);
    f = pack_frame();
    for (int r = 0; r < 2; r++) begin
      ref_decide(f, 128, e_idx, e_val, e_det);
      drive_frame(f, 128, 0, 0);
    end
    drive_frame(f, 128, 0, 5);
    m_cnt  = 0;
    m_last = SIL;
    total++;
    if (busy_v !== (32'd1 << 5) - 32'd1 || cv_v !== '0 || det_v !== '0) begin
      bad++;
      $display("FAIL abort_scan busy/cv/det got=%0h/%0h/%0h exp=%0h/0/0",
               busy_v, cv_v, det_v, (32'd1 << 5) - 32'd1);
    end
    for (int r = 0; r < 3; r++) begin
      ref_decide(f, 128, e_idx, e_val, e_det);
      drive_frame(f, 128, 0, 0);
      total++;
      if (det_v !== (32'(e_det) << N) || got_idx !== CB'(e_idx)) begin
        bad++;
        $display("FAIL abort_restreak r=%0d det got=%0h exp=%0h idx got=%0d exp=%0d",
                 r, det_v, 32'(e_det) << N, got_idx, e_idx);
      end
      $display("post-abort frame %0d: class=%0d detect=%0b", r, got_idx, det_v[N]);
    end
  endtask

  task automatic test_random();
    logic [N*AB-1:0] f;
    int e_idx, e_val, thr, win;
    bit e_det;
    win = 4;
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 9) >= 6) win = $urandom_range(0, N - 1);
      for (int i = 0; i < N; i++) sc[i] = AB'($urandom_range(0, 150));
      sc[win] = AB'($urandom_range(150, 255));
      thr = $urandom_range(100, 220);
      f = pack_frame();
      ref_decide(f, thr, e_idx, e_val, e_det);
      drive_frame(f, thr, 0, 0);
      total++;
      if (cv_v !== (32'd1 << N) || busy_v !== (32'd1 << N) - 32'd1) begin
        bad++;
        $display("FAIL rnd_timing r=%0d cv=%0h busy=%0h", r, cv_v, busy_v);
      end
      total++;
      if (got_idx !== CB'(e_idx) || got_score !== AB'(e_val)) begin
        bad++;
        $display("FAIL rnd_class r=%0d got=%0d/%0d exp=%0d/%0d", r, got_idx, got_score, e_idx, e_val);
      end
      total++;
      if (det_v !== (32'(e_det) << N)) begin
        bad++;
        $display("FAIL rnd_detect r=%0d got=%0h exp=%0h", r, det_v, 32'(e_det) << N);
      end
      $display("rnd %0d: thr=%0d class=%0d score=%0d detect=%0b", r, thr, got_idx, got_score, det_v[N]);
    end
  endtask

  initial begin
    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    threshold  = '0;
    test_reset();
    test_directed();
    test_overrun();
    test_reset_mid_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
